ray_setup: RTL and testbench

//  Per-frame ray generator sitting directly downstream of pov and upstream of the column tracer.

---
 rtl/ray_setup.sv | 156 +++++++++++++++
 tb/tb_ray_setup.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_setup.sv
// ray_setup: per-frame ray generator between pov and the column tracer.
// On each accepted frame it asks pov to commit its buffered vectors.
// It then latches the live vectors and streams one ray per screen column
// over a valid/ready handshake. Ray directions are built incrementally as
// rayDir(c) = (facing - vplane) + c * (vplane >>> (COLS_LOG2-1)).
module ray_setup #(
    parameter int Q_M       = 12,
    parameter int Q_N       = 12,
    parameter int COLS_LOG2 = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_frame_start,
    output logic                   o_load_if_ready,
    input  logic [Q_M+Q_N-1:0]     playerX,
    input  logic [Q_M+Q_N-1:0]     playerY,
    input  logic [Q_M+Q_N-1:0]     facingX,
    input  logic [Q_M+Q_N-1:0]     facingY,
    input  logic [Q_M+Q_N-1:0]     vplaneX,
    input  logic [Q_M+Q_N-1:0]     vplaneY,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [COLS_LOG2-1:0]   o_col,
    output logic [Q_M+Q_N-1:0]     o_rayDirX,
    output logic [Q_M+Q_N-1:0]     o_rayDirY,
    output logic [Q_M+Q_N-1:0]     o_playerX,
    output logic [Q_M+Q_N-1:0]     o_playerY,
    output logic [Q_M-1:0]         o_mapX,
    output logic [Q_M-1:0]         o_mapY,
    output logic                   o_stepX,
    output logic                   o_stepY,
    output logic                   o_busy,
    output logic                   o_overrun
);

    localparam int W = Q_M + Q_N;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_INIT = 2'd2,
        S_EMIT = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_load;
    logic                   r_valid;
    logic [COLS_LOG2-1:0]   r_col;
    logic                   r_overrun;

    logic                   w_accept;
    logic                   w_last;

    // Axis 0 is X, axis 1 is Y.
    logic [1:0][W-1:0]      w_player_in;
    logic [1:0][W-1:0]      w_facing_in;
    logic [1:0][W-1:0]      w_vplane_in;
    logic [1:0][W-1:0]      w_ray;
    logic [1:0][W-1:0]      w_player;

    assign w_player_in = {playerY, playerX};
    assign w_facing_in = {facingY, facingX};
    assign w_vplane_in = {vplaneY, vplaneX};

    assign w_accept = r_valid & i_ready;
    assign w_last   = (r_col == {COLS_LOG2{1'b1}});

    // Frame sequencing: IDLE -> LOAD -> INIT -> EMIT -> IDLE, plus overrun detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_load    <= 1'b0;
            r_valid   <= 1'b0;
            r_col     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_load    <= 1'b0;
            // A frame pulse while a frame is in flight is dropped and flagged.
            r_overrun <= i_frame_start && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (i_frame_start) begin
                        r_state <= S_LOAD;
                        r_load  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // pov commits its buffered vectors on this edge.
                    r_state <= S_INIT;
                end
                S_INIT: begin
                    r_state <= S_EMIT;
                    r_valid <= 1'b1;
                    r_col   <= '0;
                end
                S_EMIT: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_valid <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            logic [W-1:0] r_ray;
            logic [W-1:0] r_delta;
            logic [W-1:0] r_player;

            // Per-axis datapath: seed ray and step in INIT, then step on each non-final accept.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_ray    <= '0;
                    r_delta  <= '0;
                    r_player <= '0;
                end else if (r_state == S_INIT) begin
                    r_ray    <= w_facing_in[gi] - w_vplane_in[gi];
                    // Spans 2*vplane across 2^COLS_LOG2 columns; floor rounding error is tolerated.
                    r_delta  <= $signed(w_vplane_in[gi]) >>> (COLS_LOG2 - 1);
                    r_player <= w_player_in[gi];
                end else if (w_accept && !w_last) begin
                    r_ray <= r_ray + r_delta;
                end
            end

            assign w_ray[gi]    = r_ray;
            assign w_player[gi] = r_player;
        end
    endgenerate

    assign o_load_if_ready = r_load;
    assign o_valid         = r_valid;
    assign o_col           = r_col;
    assign o_overrun       = r_overrun;
    assign o_busy          = (r_state != S_IDLE);

    assign o_rayDirX = w_ray[0];
    assign o_rayDirY = w_ray[1];
    assign o_playerX = w_player[0];
    assign o_playerY = w_player[1];

    // Map cell is the floor of the position; step sign is the ray direction sign.
    assign o_mapX  = w_player[0][W-1:Q_N];
    assign o_mapY  = w_player[1][W-1:Q_N];
    assign o_stepX = w_ray[0][W-1];
    assign o_stepY = w_ray[1][W-1];

endmodule

// File: tb/tb_ray_setup.sv
// Testbench for ray_setup: random and directed frames, scoreboard of expected
// rays computed in closed form, monitor checking every accepted ray.
module tb_ray_setup;

    localparam int W    = 24;
    localparam int COLS = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_frame_start;
    logic        o_load_if_ready;
    logic [W-1:0] playerX, playerY, facingX, facingY, vplaneX, vplaneY;
    logic        o_valid;
    logic        i_ready;
    logic [8:0]  o_col;
    logic [W-1:0] o_rayDirX, o_rayDirY, o_playerX, o_playerY;
    logic [11:0] o_mapX, o_mapY;
    logic        o_stepX, o_stepY, o_busy, o_overrun;

    always #5 clk = ~clk;

    ray_setup #(.Q_M(12), .Q_N(12), .COLS_LOG2(9)) dut (
        .clk(clk), .reset(reset), .i_frame_start(i_frame_start),
        .o_load_if_ready(o_load_if_ready),
        .playerX(playerX), .playerY(playerY),
        .facingX(facingX), .facingY(facingY),
        .vplaneX(vplaneX), .vplaneY(vplaneY),
        .o_valid(o_valid), .i_ready(i_ready), .o_col(o_col),
        .o_rayDirX(o_rayDirX), .o_rayDirY(o_rayDirY),
        .o_playerX(o_playerX), .o_playerY(o_playerY),
        .o_mapX(o_mapX), .o_mapY(o_mapY),
        .o_stepX(o_stepX), .o_stepY(o_stepY),
        .o_busy(o_busy), .o_overrun(o_overrun)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          col;
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic [W-1:0] px;
        logic [W-1:0] py;
    } ray_t;

    ray_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Closed-form ray direction: (f - v) + c * floor(v / 2^(COLS_LOG2-1)), mod 2^W.
    function automatic logic [W-1:0] exp_dir(input logic [W-1:0] f, input logic [W-1:0] v, input int c);
        longint fv, vv, d, r;
        fv = longint'($signed(f));
        vv = longint'($signed(v));
        d  = vv / 256;
        if (vv < 0 && (vv % 256) != 0) d = d - 1;
        r  = fv - vv + longint'(c) * d;
        return r[W-1:0];
    endfunction

    task automatic push_frame();
        ray_t e;
        for (int c = 0; c < COLS; c++) begin
            e.col = c;
            e.rx  = exp_dir(facingX, vplaneX, c);
            e.ry  = exp_dir(facingY, vplaneY, c);
            e.px  = playerX;
            e.py  = playerY;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: compare every accepted ray against the scoreboard, and check
    // that a stalled ray stays put until it is taken.
    logic         held = 1'b0;
    logic [8:0]   h_col;
    logic [W-1:0] h_rx, h_ry;

    always @(negedge clk) begin
        ray_t e;
        if (reset) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", {31'd0, o_valid}, 32'd1);
                chk("hold_col", {23'd0, o_col}, {23'd0, h_col});
                chk("hold_rayX", {8'd0, o_rayDirX}, {8'd0, h_rx});
                chk("hold_rayY", {8'd0, o_rayDirY}, {8'd0, h_ry});
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ray: got col %0d, expected no ray", o_col);
                end else begin
                    e = exp_q.pop_front();
                    $display("ray col=%0d rayX=%h rayY=%h", o_col, o_rayDirX, o_rayDirY);
                    chk("col", {23'd0, o_col}, e.col);
                    chk("rayDirX", {8'd0, o_rayDirX}, {8'd0, e.rx});
                    chk("rayDirY", {8'd0, o_rayDirY}, {8'd0, e.ry});
                    chk("playerX", {8'd0, o_playerX}, {8'd0, e.px});
                    chk("playerY", {8'd0, o_playerY}, {8'd0, e.py});
                    chk("mapX", {20'd0, o_mapX}, {20'd0, e.px[23:12]});
                    chk("mapY", {20'd0, o_mapY}, {20'd0, e.py[23:12]});
                    chk("stepX", {31'd0, o_stepX}, {31'd0, e.rx[23]});
                    chk("stepY", {31'd0, o_stepY}, {31'd0, e.ry[23]});
                end
            end
            held  = o_valid && !i_ready;
            h_col = o_col;
            h_rx  = o_rayDirX;
            h_ry  = o_rayDirY;
        end
    end

    // mode 0: ready always high; 1: random ready; 2: 5-cycle stall at col 10.
    // ovr_col >= 0 injects a frame pulse there; rst_col >= 0 asserts reset there.
    task automatic run_frame(input int mode, input int ovr_col, input int rst_col);
        int cyc = 0;
        int bp = 0;
        int ovr_pending = 0;
        bit ovr_done = 0;
        bit aborted = 0;
        push_frame();
        i_ready = 1'b1;
        i_frame_start = 1'b1;
        @(posedge clk); #1;
        i_frame_start = 1'b0;
        chk("load_pulse", {31'd0, o_load_if_ready}, 32'd1);
        chk("busy_load", {31'd0, o_busy}, 32'd1);
        chk("no_overrun_idle", {31'd0, o_overrun}, 32'd0);
        chk("valid_load", {31'd0, o_valid}, 32'd0);
        @(posedge clk); #1;
        chk("load_once", {31'd0, o_load_if_ready}, 32'd0);
        chk("valid_init", {31'd0, o_valid}, 32'd0);
        @(posedge clk); #1;
        chk("first_valid", {31'd0, o_valid}, 32'd1);
        chk("first_col", {23'd0, o_col}, 32'd0);
        chk("first_rayX", {8'd0, o_rayDirX}, {8'd0, exp_dir(facingX, vplaneX, 0)});
        while (o_busy && cyc < 4000) begin
            case (mode)
                1: i_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (o_col == 9'd10 && bp < 5) begin
                        i_ready = 1'b0;
                        bp++;
                    end else begin
                        i_ready = 1'b1;
                    end
                end
                default: i_ready = 1'b1;
            endcase
            if (ovr_col >= 0 && !ovr_done && int'(o_col) == ovr_col) begin
                i_frame_start = 1'b1;
                ovr_done = 1;
                ovr_pending = 1;
            end
            if (rst_col >= 0 && int'(o_col) == rst_col) begin
                #2 reset = 1'b1;
                #1;
                chk("rst_valid_async", {31'd0, o_valid}, 32'd0);
                chk("rst_busy_async", {31'd0, o_busy}, 32'd0);
                chk("rst_col_async", {23'd0, o_col}, 32'd0);
                exp_q.delete();
                @(posedge clk); #1;
                reset = 1'b0;
                aborted = 1;
                break;
            end
            @(posedge clk); #1;
            i_frame_start = 1'b0;
            if (ovr_pending == 2) begin
                chk("overrun_one_cycle", {31'd0, o_overrun}, 32'd0);
                ovr_pending = 0;
            end
            if (ovr_pending == 1) begin
                chk("overrun_pulse", {31'd0, o_overrun}, 32'd1);
                chk("overrun_no_load", {31'd0, o_load_if_ready}, 32'd0);
                ovr_pending = 2;
            end
            cyc++;
        end
        if (cyc >= 4000) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got busy after %0d cycles, expected done", cyc);
        end
        if (!aborted) begin
            chk("end_valid", {31'd0, o_valid}, 32'd0);
            chk("end_busy", {31'd0, o_busy}, 32'd0);
            chk("all_rays_seen", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        @(posedge clk); #1;
        if (ovr_pending == 2)
            chk("overrun_one_cycle", {31'd0, o_overrun}, 32'd0);
        chk("idle_no_load", {31'd0, o_load_if_ready}, 32'd0);
        chk("idle_busy", {31'd0, o_busy}, 32'd0);
    endtask

    task automatic set_defaults();
        playerX = 24'h001800; playerY = 24'h001800;
        facingX = 24'h000000; facingY = 24'h001000;
        vplaneX = 24'hFFF800; vplaneY = 24'h000000;
    endtask

    initial begin
        reset = 1'b1;
        i_frame_start = 1'b0;
        i_ready = 1'b0;
        set_defaults();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, o_valid}, 32'd0);
        chk("reset_load", {31'd0, o_load_if_ready}, 32'd0);
        chk("reset_busy", {31'd0, o_busy}, 32'd0);
        chk("reset_col", {23'd0, o_col}, 32'd0);
        chk("reset_rayX", {8'd0, o_rayDirX}, 32'd0);
        chk("reset_playerX", {8'd0, o_playerX}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Default pov vectors: delta -8 LSB, col0 rayX 0x000800, col511 0xFFF808.
        chk("model_col0", {8'd0, exp_dir(facingX, vplaneX, 0)}, 32'h000800);
        chk("model_col511", {8'd0, exp_dir(facingX, vplaneX, 511)}, 32'hFFF808);
        run_frame(0, -1, -1);
        run_frame(2, -1, -1);
        run_frame(0, 100, -1);
        run_frame(0, 511, -1);
        run_frame(0, -1, 200);
        run_frame(0, -1, -1);

        // Negative position and wrapping direction.
        playerX = 24'hFFFC00;
        facingX = 24'h7FF000;
        vplaneX = 24'h800000;
        run_frame(1, -1, -1);

        for (int f = 0; f < 2; f++) begin
            playerX = 24'($urandom); playerY = 24'($urandom);
            facingX = 24'($urandom); facingY = 24'($urandom);
            vplaneX = 24'($urandom); vplaneY = 24'($urandom);
            run_frame(1, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
